// File: rtl/wb_reg_pkg.sv
// Shared types and constants for the Wishbone register target.
// FSM encoding, register-map offset helpers and the miss read value.
package wb_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int MAX_DATA_WIDTH = 64;

    // Decode misses read back as all-ones; sliced to the bus width by the user.
    localparam logic [MAX_DATA_WIDTH-1:0] MISS_RDATA = '1;

    function automatic int status_offset(input int reg_count);
        return reg_count - 2;
    endfunction

    function automatic int id_offset(input int reg_count);
        return reg_count - 1;
    endfunction

endpackage

// File: rtl/wb_reg_target.sv
// Wishbone B4 pipelined register target: R/W control regs, W1C status with irq, read-only ID.
// Latency: ack WAIT_STATES+1 cycles after the accept edge; one transaction outstanding.
// Backpressure: stall is high from accept through the ack cycle; strobes seen while stalled are ignored.
module wb_reg_target
    import wb_reg_pkg::*;
#(
    parameter int                       WB_ADDR_WIDTH = 20,
    parameter int                       DATA_WIDTH    = 8,
    parameter int                       REG_COUNT     = 8,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = 20'hF0000,
    parameter int                       WAIT_STATES   = 1,
    parameter logic [DATA_WIDTH-1:0]    ID_VALUE      = 8'hA5
) (
    input  logic                                  wb_clock_i,
    input  logic                                  wb_reset_ni,
    input  logic [WB_ADDR_WIDTH-1:0]              wb_addr_i,
    input  logic [DATA_WIDTH-1:0]                 wb_data_i,
    output logic [DATA_WIDTH-1:0]                 wb_data_o,
    input  logic                                  wb_we_i,
    input  logic                                  wb_cycle_i,
    input  logic                                  wb_strobe_i,
    output logic                                  wb_stall_o,
    output logic                                  wb_ack_o,
    input  logic [DATA_WIDTH-1:0]                 event_i,
    output logic [(REG_COUNT-2)*DATA_WIDTH-1:0]   ctrl_o,
    output logic                                  irq_o
);

    localparam int IDXW  = $clog2(REG_COUNT);
    localparam int NCTRL = REG_COUNT - 2;

    localparam logic [IDXW-1:0]       STATUS_OFF = IDXW'(status_offset(REG_COUNT));
    localparam logic [IDXW-1:0]       ID_OFF     = IDXW'(id_offset(REG_COUNT));
    localparam logic [2:0]            CNT_INIT   = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [DATA_WIDTH-1:0] MISS_VAL   = MISS_RDATA[DATA_WIDTH-1:0];

    state_t                     state_q, state_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic [WB_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wdat_q, wdat_d;
    logic                       we_q, we_d;
    logic [DATA_WIDTH-1:0]      rdat_q, rdat_d;
    logic [DATA_WIDTH-1:0]      ctrl_q [NCTRL];
    logic [DATA_WIDTH-1:0]      ctrl_d [NCTRL];
    logic [DATA_WIDTH-1:0]      status_q, status_d;
    logic                       irq_q, irq_d;

    logic                       commit;
    logic [WB_ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]      req_wdat;
    logic                       req_we;
    logic                       hit;
    logic [IDXW-1:0]            req_off;
    logic [DATA_WIDTH-1:0]      rd_val;
    logic [DATA_WIDTH-1:0]      clear_mask;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb_cycle_i && wb_strobe_i) begin
                    addr_d = wb_addr_i;
                    wdat_d = wb_data_i;
                    we_d   = wb_we_i;
                    cnt_d  = CNT_INIT;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_ACK;
                        commit  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Initiator abandoning the cycle cancels the access before anything commits.
                if (!wb_cycle_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 3'd0) begin
                    state_d = ST_ACK;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // With zero wait states the commit happens on the accept edge, so use the live bus.
        req_addr = (state_q == ST_IDLE) ? wb_addr_i : addr_q;
        req_wdat = (state_q == ST_IDLE) ? wb_data_i : wdat_q;
        req_we   = (state_q == ST_IDLE) ? wb_we_i   : we_q;
        hit      = (req_addr[WB_ADDR_WIDTH-1:IDXW] == BASE_ADDR[WB_ADDR_WIDTH-1:IDXW]);
        req_off  = req_addr[IDXW-1:0];

        rd_val = MISS_VAL;
        if (hit) begin
            if (req_off == ID_OFF) begin
                rd_val = ID_VALUE;
            end else if (req_off == STATUS_OFF) begin
                rd_val = status_q;
            end else begin
                for (int i = 0; i < NCTRL; i++) begin
                    if (req_off == IDXW'(i)) rd_val = ctrl_q[i];
                end
            end
        end

        clear_mask = '0;
        for (int i = 0; i < NCTRL; i++) ctrl_d[i] = ctrl_q[i];
        if (commit && hit && req_we) begin
            if (req_off == STATUS_OFF) clear_mask = req_wdat;
            for (int i = 0; i < NCTRL; i++) begin
                if (req_off == IDXW'(i)) ctrl_d[i] = req_wdat;
            end
        end

        rdat_d   = commit ? rd_val : rdat_q;
        // Events are OR'd in after the clear so a simultaneous event keeps its bit set.
        status_d = (status_q & ~clear_mask) | event_i;
        irq_d    = |status_q;
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            addr_q   <= '0;
            wdat_q   <= '0;
            we_q     <= 1'b0;
            rdat_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < NCTRL; i++) ctrl_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            we_q     <= we_d;
            rdat_q   <= rdat_d;
            status_q <= status_d;
            irq_q    <= irq_d;
            for (int i = 0; i < NCTRL; i++) ctrl_q[i] <= ctrl_d[i];
        end
    end

    assign wb_ack_o   = (state_q == ST_ACK);
    assign wb_stall_o = (state_q != ST_IDLE);
    assign wb_data_o  = rdat_q;
    assign irq_o      = irq_q;

    for (genvar g = 0; g < NCTRL; g++) begin : g_ctrl
        assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
    end

endmodule

// File: tb/tb_wb_reg_target.sv
// Bench for wb_reg_target: directed register-map scenarios plus randomized traffic,
// all outputs compared every cycle against a cycle-level behavioural model.
module tb_wb_reg_target;

    localparam int         WS   = 1;
    localparam logic [19:0] BASE = 20'hF0000;
    localparam logic [7:0]  IDV  = 8'hA5;

    logic        clk;
    logic        rst_n;
    logic [19:0] wb_addr_i;
    logic [7:0]  wb_data_i;
    logic [7:0]  wb_data_o;
    logic        wb_we_i;
    logic        wb_cycle_i;
    logic        wb_strobe_i;
    logic        wb_stall_o;
    logic        wb_ack_o;
    logic [7:0]  event_i;
    logic [47:0] ctrl_o;
    logic        irq_o;

    wb_reg_target #(
        .WB_ADDR_WIDTH(20), .DATA_WIDTH(8), .REG_COUNT(8),
        .BASE_ADDR(BASE), .WAIT_STATES(WS), .ID_VALUE(IDV)
    ) dut (
        .wb_clock_i(clk), .wb_reset_ni(rst_n),
        .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_data_o(wb_data_o),
        .wb_we_i(wb_we_i), .wb_cycle_i(wb_cycle_i), .wb_strobe_i(wb_strobe_i),
        .wb_stall_o(wb_stall_o), .wb_ack_o(wb_ack_o),
        .event_i(event_i), .ctrl_o(ctrl_o), .irq_o(irq_o)
    );

    initial clk = 1'b0;
    always #8 clk = ~clk;

    // ---------------- behavioural model ----------------
    int         edge_n;
    int         m_ack_edge;
    logic       m_pend, m_ackph, m_irq, m_rdchk;
    logic [7:0] m_st, m_old, m_clr, m_rd;
    logic [7:0] m_ctrl [6];
    logic       t_we;
    logic [19:0] t_addr;
    logic [7:0] t_dat;

    function automatic logic [47:0] pack_ctrl();
        logic [47:0] v;
        for (int i = 0; i < 6; i++) v[i*8 +: 8] = m_ctrl[i];
        return v;
    endfunction

    task automatic m_commit();
        logic       h;
        logic [2:0] off;
        h   = ((t_addr >> 3) == (BASE >> 3));
        off = t_addr[2:0];
        if (!h)            m_rd = 8'hFF;
        else if (off < 6)  m_rd = m_ctrl[off];
        else if (off == 6) m_rd = m_old;
        else               m_rd = IDV;
        if (h && t_we) begin
            if (off < 6)       m_ctrl[off] = t_dat;
            else if (off == 6) m_clr = t_dat;
        end
        m_rdchk = !t_we;
        m_ackph = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_n = 0; m_pend = 0; m_ackph = 0; m_irq = 0; m_st = 0;
            m_rd = 0; m_rdchk = 0; m_ack_edge = 0;
            for (int i = 0; i < 6; i++) m_ctrl[i] = 8'h00;
        end else begin
            edge_n++;
            m_old = m_st;
            m_clr = 8'h00;
            if (m_ackph) begin
                m_ackph = 1'b0;
            end else if (m_pend) begin
                if (!wb_cycle_i) m_pend = 1'b0;
                else if (edge_n == m_ack_edge) begin
                    m_pend = 1'b0;
                    m_commit();
                end
            end else if (wb_cycle_i && wb_strobe_i) begin
                t_we = wb_we_i; t_addr = wb_addr_i; t_dat = wb_data_i;
                if (WS == 0) m_commit();
                else begin
                    m_pend     = 1'b1;
                    m_ack_edge = edge_n + WS;
                end
            end
            m_st  = (m_old & ~m_clr) | event_i;
            m_irq = |m_old;
        end
    end

    // ---------------- checking ----------------
    int          n_chk  = 0;
    int          n_fail = 0;
    logic        s_ack, s_stall, s_irq;
    logic [7:0]  s_data;
    logic [47:0] s_ctrl;
    logic [7:0]  ev_once = 8'h00;
    logic        ev_rand = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle: compare at the falling edge, then drive new event bits after the rising edge.
    task automatic tick();
        logic [7:0] ev;
        @(negedge clk);
        s_ack = wb_ack_o; s_stall = wb_stall_o; s_irq = irq_o;
        s_data = wb_data_o; s_ctrl = ctrl_o;
        if (!rst_n) begin
            chk("rst_ack", s_ack, 0);
            chk("rst_stall", s_stall, 0);
            chk("rst_data", s_data, 0);
            chk("rst_irq", s_irq, 0);
            chk("rst_ctrl", s_ctrl, 0);
        end else begin
            chk("ack", s_ack, m_ackph);
            chk("stall", s_stall, m_pend | m_ackph);
            chk("irq", s_irq, m_irq);
            chk("ctrl", s_ctrl, pack_ctrl());
            if (m_ackph && m_rdchk) chk("rdata", s_data, m_rd);
        end
        @(posedge clk);
        #1;
        ev = 8'h00;
        if (ev_rand && $urandom_range(0, 7) == 0) ev = 8'h01 << $urandom_range(0, 7);
        event_i = ev_once | ev;
        ev_once = 8'h00;
    endtask

    task automatic bus(input logic we, input logic [19:0] a, input logic [7:0] d,
                       input logic abort, input logic hold, input logic [7:0] ev_c,
                       output logic [7:0] rd, output int lat, output logic acked);
        logic got;
        rd = 8'h00; lat = 0; acked = 1'b0; got = 1'b0;
        wb_cycle_i = 1'b1; wb_strobe_i = 1'b1;
        wb_addr_i = a; wb_we_i = we; wb_data_i = d;
        for (int k = 0; k < 16 && !got; k++) begin
            tick();
            if (!s_stall) got = 1'b1;
        end
        chk("accept", got, 1);
        if (!hold) wb_strobe_i = 1'b0;
        if (ev_c != 8'h00) event_i = ev_c;
        if (abort) begin
            wb_cycle_i = 1'b0; wb_strobe_i = 1'b0;
            for (int j = 0; j < 3; j++) begin
                tick();
                if (s_ack) acked = 1'b1;
            end
        end else begin
            for (int j = 1; j <= 16 && !acked; j++) begin
                tick();
                if (s_ack) begin
                    acked = 1'b1; rd = s_data; lat = j;
                end
            end
            chk("ack_seen", acked, 1);
        end
        wb_cycle_i = 1'b0; wb_strobe_i = 1'b0;
    endtask

    logic [7:0] r;
    int         l;
    logic       ak;

    task automatic wr(input logic [19:0] a, input logic [7:0] d);
        bus(1'b1, a, d, 1'b0, 1'b0, 8'h00, r, l, ak);
    endtask

    task automatic rd_chk(input string nm, input logic [19:0] a, input logic [7:0] exp);
        bus(1'b0, a, 8'h00, 1'b0, 1'b0, 8'h00, r, l, ak);
        chk(nm, r, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wb_addr_i = '0; wb_data_i = '0; wb_we_i = 1'b0;
        wb_cycle_i = 1'b0; wb_strobe_i = 1'b0; event_i = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Control register write/read and latency
        wr(BASE, 8'h3C);
        chk("wr_latency", l, 2);
        chk("ctrl0_at_ack", s_ctrl[7:0], 8'h3C);
        rd_chk("rd_ctrl0", BASE, 8'h3C);
        chk("rd_latency", l, 2);

        // ID register is read-only
        rd_chk("rd_id", BASE + 20'd7, 8'hA5);
        wr(BASE + 20'd7, 8'h00);
        rd_chk("rd_id_after_wr", BASE + 20'd7, 8'hA5);

        // Status events, irq lag and write-1-to-clear
        ev_once = 8'h81;
        tick(); tick(); tick();
        chk("irq_lag", s_irq, 0);
        tick();
        chk("irq_rise", s_irq, 1);
        rd_chk("rd_status_81", BASE + 20'd6, 8'h81);
        wr(BASE + 20'd6, 8'h01);
        rd_chk("rd_status_80", BASE + 20'd6, 8'h80);
        chk("irq_held", s_irq, 1);
        wr(BASE + 20'd6, 8'h80);
        rd_chk("rd_status_00", BASE + 20'd6, 8'h00);
        chk("irq_fall", s_irq, 0);

        // Event beats a simultaneous clear
        ev_once = 8'h01;
        tick(); tick();
        bus(1'b1, BASE + 20'd6, 8'h01, 1'b0, 1'b0, 8'h01, r, l, ak);
        rd_chk("event_wins", BASE + 20'd6, 8'h01);
        wr(BASE + 20'd6, 8'h01);
        rd_chk("status_cleared", BASE + 20'd6, 8'h00);

        // Decode miss
        rd_chk("rd_miss", 20'h00010, 8'hFF);
        chk("miss_latency", l, 2);
        wr(20'h00010, 8'h5A);
        chk("miss_wr_ctrl", s_ctrl, 48'h0000_0000_003C);

        // Abort during WAIT
        wr(BASE + 20'd1, 8'h77);
        bus(1'b1, BASE + 20'd1, 8'h55, 1'b1, 1'b0, 8'h00, r, l, ak);
        chk("abort_no_ack", ak, 0);
        rd_chk("abort_no_write", BASE + 20'd1, 8'h77);

        // Reset asserted mid-WAIT
        wb_cycle_i = 1'b1; wb_strobe_i = 1'b1; wb_we_i = 1'b1;
        wb_addr_i = BASE + 20'd2; wb_data_i = 8'h99;
        tick();
        wb_strobe_i = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        chk("midrst_ack", s_ack, 0);
        chk("midrst_stall", s_stall, 0);
        chk("midrst_ctrl", s_ctrl, 48'h0);
        wb_cycle_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        wr(BASE + 20'd2, 8'h99);
        chk("post_rst_latency", l, 2);
        rd_chk("post_rst_rd2", BASE + 20'd2, 8'h99);
        rd_chk("post_rst_rd0", BASE, 8'h00);

        // Randomized traffic with random events; model checks every cycle
        ev_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [19:0] a;
            logic        ab;
            if ($urandom_range(0, 4) == 0) begin
                a = 20'($urandom);
                if ((a >> 3) == (BASE >> 3)) a = a ^ 20'h80000;
            end else begin
                a = BASE | 20'($urandom_range(0, 7));
            end
            ab = ($urandom_range(0, 9) == 0);
            bus(1'($urandom_range(0, 1)), a, 8'($urandom), ab,
                ($urandom_range(0, 3) == 0), 8'h00, r, l, ak);
            if (!ab) chk("rand_latency", l, 2);
            repeat ($urandom_range(0, 2)) tick();
        end
        ev_rand = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
